// File: rtl/tick_generator.sv
// Multi-channel tick enable generator: N_CH independent single-cycle ticks with runtime divisors.
// Optional square-wave outputs (sq_out) are built when TICK_GEN_SQUARE_EN is defined.
module tick_generator #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              run_in,
  input  logic              clear_in,
  input  logic [N_CH-1:0]   load_in,
  input  logic [DIV_W-1:0]  div_in,
  output logic [N_CH-1:0]   tick_out,
  output logic [N_CH-1:0]   pending_out
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [N_CH-1:0]   sq_out
`endif
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_cnt [N_CH];
  logic [DIV_W-1:0] r_div [N_CH];
  logic [DIV_W-1:0] r_shd [N_CH];
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_tick;

  logic [DIV_W-1:0] w_last [N_CH];
  logic [N_CH-1:0]  w_wrap;

  // A divisor of 0 behaves as 1, so its terminal count is 0 like a divisor of 1.
  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_last[i] = (r_div[i] == '0) ? '0 : r_div[i] - DIV_W'(1);
      w_wrap[i] = run_in && (r_cnt[i] == w_last[i]);
    end
  end

  // NOTE: every state element, arrays included, is reset and updated with
  // non-blocking assignments so all channels see the same pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
        r_div[i] <= RESET_DIV;
        r_shd[i] <= RESET_DIV;
      end
      r_pend <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clear_in) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else if (w_wrap[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
        end else if (run_in) begin
          r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
          r_tick[i] <= 1'b0;
        end else begin
          r_tick[i] <= 1'b0;
        end

        if (load_in[i]) begin
          r_shd[i] <= div_in;
        end

        // Period boundary: a same-cycle load wins over an older pending shadow.
        if (clear_in || w_wrap[i]) begin
          if (load_in[i]) begin
            r_div[i] <= div_in;
          end else if (r_pend[i]) begin
            r_div[i] <= r_shd[i];
          end
          r_pend[i] <= 1'b0;
        end else if (load_in[i]) begin
          r_pend[i] <= 1'b1;
        end
      end
    end
  end

  assign tick_out    = r_tick;
  assign pending_out = r_pend;

`ifdef TICK_GEN_SQUARE_EN
  logic [N_CH-1:0] r_sq;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sq <= '0;
    end else if (clear_in) begin
      r_sq <= '0;
    end else begin
      r_sq <= r_sq ^ w_wrap;
    end
  end

  assign sq_out = r_sq;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: expected tick/pending vectors are queued per driven
// cycle and compared one time unit after the following rising edge.
module tb_tick_generator;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DDIV  = 5;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              run_in;
  logic              clear_in;
  logic [N_CH-1:0]   load_in;
  logic [DIV_W-1:0]  div_in;
  logic [N_CH-1:0]   tick_out;
  logic [N_CH-1:0]   pending_out;
`ifdef TICK_GEN_SQUARE_EN
  logic [N_CH-1:0]   sq_out;
`endif

  typedef struct packed {
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pend;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  tick_generator #(
    .N_CH        (N_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .run_in      (run_in),
    .clear_in    (clear_in),
    .load_in     (load_in),
    .div_in      (div_in),
    .tick_out    (tick_out),
    .pending_out (pending_out)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .sq_out      (sq_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_in = 1'b1;
    run_in   = 1'b0;
    clear_in = 1'b0;
    load_in  = '0;
    div_in   = '0;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    run_in   = 1'b1;
    clear_in = 1'b0;
    load_in  = '0;
    div_in   = '0;
    #1;
    checks++;
    if (tick_out !== '0) begin
      errors++;
      $display("FAIL reset_tick got %b expected %b", tick_out, 2'b00);
    end
    checks++;
    if (pending_out !== '0) begin
      errors++;
      $display("FAIL reset_pend got %b expected %b", pending_out, 2'b00);
    end
    @(posedge clk_in); #1;
    checks++;
    if (tick_out !== '0) begin
      errors++;
      $display("FAIL reset_held_tick got %b expected %b", tick_out, 2'b00);
    end
    reset_in = 1'b0;
  endtask

  // Both channels on the default divisor: a tick on every 5th edge.
  task automatic test_default_period();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      run_in  = 1'b1;
      e.tick  = (k % DDIV == 0) ? 2'b11 : 2'b00;
      e.pend  = 2'b00;
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL default_period edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL default_period edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
`ifdef TICK_GEN_SQUARE_EN
      checks++;
      if (sq_out !== (((k / DDIV) % 2 == 1) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL square edge %0d sq_out got %b expected %b", k, sq_out,
                 (((k / DDIV) % 2 == 1) ? 2'b11 : 2'b00));
      end
`endif
    end
  endtask

  // Load 3 into ch0 at edge 7; it applies after the wrap at edge 10.
  task automatic test_deferred_load();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      run_in  = 1'b1;
      load_in = (k == 7) ? 2'b01 : 2'b00;
      div_in  = 16'd3;
      e.tick[0] = (k <= 10) ? (k % 5 == 0) : ((k - 10) % 3 == 0);
      e.tick[1] = (k % 5 == 0);
      e.pend    = {1'b0, (k >= 7 && k <= 9)};
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL deferred_load edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL deferred_load edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
    end
    load_in = '0;
  endtask

  // run_in low on edges 3..5 pushes the first tick from edge 5 to edge 8.
  task automatic test_stall();
    exp_t e, got;
    int   n_run;
    do_reset();
    n_run = 0;
    for (int k = 1; k <= 15; k++) begin
      run_in = !(k >= 3 && k <= 5);
      if (run_in) n_run++;
      e.tick = (run_in && (n_run % 5 == 0)) ? 2'b11 : 2'b00;
      e.pend = 2'b00;
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL stall edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
    end
    run_in = 1'b1;
  endtask

  // Load 2 on ch1 at edge 3, clear at edge 4: shadow applied, both restart from 0.
  task automatic test_clear_pending();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      run_in   = 1'b1;
      clear_in = (k == 4);
      load_in  = (k == 3) ? 2'b10 : 2'b00;
      div_in   = 16'd2;
      e.tick[1] = (k > 4) && ((k - 4) % 2 == 0);
      e.tick[0] = (k > 4) && ((k - 4) % 5 == 0);
      e.pend    = {(k == 3), 1'b0};
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL clear_pending edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL clear_pending edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
    end
    clear_in = 1'b0;
    load_in  = '0;
  endtask

  // Load 0 into ch0 on its wrap edge: ticks every cycle at once, never pending.
  task automatic test_zero_on_wrap();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      run_in  = 1'b1;
      load_in = (k == 5) ? 2'b01 : 2'b00;
      div_in  = 16'd0;
      e.tick[0] = (k < 5) ? 1'b0 : 1'b1;
      e.tick[1] = (k % 5 == 0);
      e.pend    = 2'b00;
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL zero_on_wrap edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL zero_on_wrap edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
    end
    load_in = '0;
  endtask

  // Two loads before the wrap on ch1: only the later value (4) takes effect.
  task automatic test_back_to_back();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      run_in  = 1'b1;
      load_in = (k == 2 || k == 3) ? 2'b10 : 2'b00;
      div_in  = (k == 2) ? 16'd2 : 16'd4;
      e.tick[0] = (k % 5 == 0);
      e.tick[1] = (k <= 5) ? (k == 5) : ((k - 5) % 4 == 0);
      e.pend    = {(k >= 2 && k <= 4), 1'b0};
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL back_to_back edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL back_to_back edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
    end
    load_in = '0;
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic test_async_reset();
    exp_t e, got;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run_in  = 1'b1;
      load_in = (k == 3) ? 2'b10 : 2'b00;
      div_in  = 16'd7;
      e.tick  = 2'b00;
      e.pend  = {(k >= 3), 1'b0};
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (pending_out !== got.pend) begin
        errors++;
        $display("FAIL async_reset_pre edge %0d pending_out got %b expected %b", k, pending_out, got.pend);
      end
    end
    load_in = '0;
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if (pending_out !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_pend got %b expected %b", pending_out, 2'b00);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      run_in = 1'b1;
      e.tick = (k == 5) ? 2'b11 : 2'b00;
      e.pend = 2'b00;
      sb.push_back(e);
      @(posedge clk_in); #1;
      got = sb.pop_front();
      checks++;
      if (tick_out !== got.tick) begin
        errors++;
        $display("FAIL async_reset_restart edge %0d tick_out got %b expected %b", k, tick_out, got.tick);
      end
    end
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if (tick_out !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_tick got %b expected %b", tick_out, 2'b00);
    end
`ifdef TICK_GEN_SQUARE_EN
    checks++;
    if (sq_out !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_sq got %b expected %b", sq_out, 2'b00);
    end
`endif
    reset_in = 1'b0;
    run_in   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_deferred_load();
    test_stall();
    test_clear_pending();
    test_zero_on_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
